// File: rtl/usb_rx_decoder.sv
// usb_rx_decoder
// Receive-side line decoder for a snooped USB bus. Synchronizes the raw
// dp/dm pair, recovers bit timing with an oversampling DPLL, NRZI-decodes,
// removes stuffed bits, detects SYNC and assembles bytes (LSB first). The
// first byte of each packet is checked as a PID (low nibble must be the
// complement of the high nibble).
//
// Ports
//   clk        system clock (48 MHz)
//   rst        asynchronous active-high reset
//   is_fs      1 = full-speed rate/polarity, 0 = low-speed (sampled in IDLE)
//   line_dp    raw D+ (asynchronous)
//   line_dm    raw D- (asynchronous)
//   rx_active  high from SYNC detect until EOP/abort handling completes
//   rx_data    assembled byte, held until the next rx_valid
//   rx_valid   one-cycle strobe, rx_data valid
//   rx_first   qualifies rx_valid: this byte is the PID
//   rx_eop     one-cycle strobe, clean end of packet
//   rx_err     one-cycle strobe, packet aborted (stuff, PID or EOP error)
module usb_rx_decoder #(
  parameter int CPB_FS = 4,
  parameter int CPB_LS = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       is_fs,
  input  logic       line_dp,
  input  logic       line_dm,
  output logic       rx_active,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       rx_eop,
  output logic       rx_err
);

  localparam int CPB_MAX = (CPB_FS > CPB_LS) ? CPB_FS : CPB_LS;
  localparam int PW      = $clog2(CPB_MAX);

  localparam logic [PW-1:0] FS_LAST = PW'(CPB_FS - 1);
  localparam logic [PW-1:0] LS_LAST = PW'(CPB_LS - 1);
  localparam logic [PW-1:0] FS_HALF = PW'(CPB_FS / 2);
  localparam logic [PW-1:0] LS_HALF = PW'(CPB_LS / 2);

  typedef enum logic [1:0] {
    LINE_SE0 = 2'd0,
    LINE_J   = 2'd1,
    LINE_K   = 2'd2
  } line_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_DATA  = 3'd2,
    ST_EOP   = 3'd3,
    ST_ABORT = 3'd4
  } state_t;

  // Classify a synchronized dp/dm pair. K polarity flips with the speed mode;
  // anything that is neither SE0 nor K (including SE1) is treated as J.
  function automatic line_t decode_line(input logic dp, input logic dm, input logic fs);
    line_t res;
    if (!dp && !dm) begin
      res = LINE_SE0;
    end else if (fs ? (!dp && dm) : (dp && !dm)) begin
      res = LINE_K;
    end else begin
      res = LINE_J;
    end
    return res;
  endfunction

  // Input synchronizer and mode register
  logic dp_meta_r, dp_sync_r, dm_meta_r, dm_sync_r;
  logic fs_r;

  // DPLL
  line_t         line_cur_s;
  line_t         line_prev_r;
  logic [PW-1:0] phase_r, phase_nxt_s;
  logic [PW-1:0] last_s, half_s;
  logic          change_s, sample_en_s;

  // Decoder state
  state_t     state_r, state_nxt_s;
  line_t      nrzi_prev_r, nrzi_prev_nxt_s;
  logic [4:0] zero_run_r, zero_run_nxt_s;
  logic [2:0] ones_r, ones_nxt_s;
  logic [2:0] bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0] shift_r, shift_nxt_s;
  logic       first_r, first_nxt_s;
  logic       pend_err_r, pend_err_nxt_s;
  logic [1:0] se0_cnt_r, se0_cnt_nxt_s;
  logic       abort_se0_r, abort_se0_nxt_s;
  logic       bit_s;
  logic [7:0] byte_s;

  // Output next values
  logic       active_nxt_s;
  logic [7:0] data_nxt_s;
  logic       valid_nxt_s, first_out_nxt_s, eop_nxt_s, err_nxt_s;

  // Two-flop synchronizer on dp/dm; the speed mode only follows is_fs in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_meta_r <= 1'b0;
      dp_sync_r <= 1'b0;
      dm_meta_r <= 1'b0;
      dm_sync_r <= 1'b0;
      fs_r      <= 1'b1;
    end else begin
      dp_meta_r <= line_dp;
      dp_sync_r <= dp_meta_r;
      dm_meta_r <= line_dm;
      dm_sync_r <= dm_meta_r;
      fs_r      <= (state_r == ST_IDLE) ? is_fs : fs_r;
    end
  end

  // DPLL: any line-state change re-centres the phase; sample at mid-bit
  always_comb begin
    line_cur_s = decode_line(dp_sync_r, dm_sync_r, fs_r);
    last_s     = fs_r ? FS_LAST : LS_LAST;
    half_s     = fs_r ? FS_HALF : LS_HALF;
    change_s   = (line_cur_s != line_prev_r);
    if (change_s) begin
      phase_nxt_s = '0;
    end else if (phase_r >= last_s) begin
      phase_nxt_s = '0;
    end else begin
      phase_nxt_s = phase_r + PW'(1);
    end
    sample_en_s = !change_s && (phase_r == half_s);
  end

  // DPLL registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_prev_r <= LINE_SE0;
      phase_r     <= '0;
    end else begin
      line_prev_r <= line_cur_s;
      phase_r     <= phase_nxt_s;
    end
  end

  // Decoder FSM: next state, datapath and output strobes
  always_comb begin
    state_nxt_s     = state_r;
    nrzi_prev_nxt_s = nrzi_prev_r;
    zero_run_nxt_s  = zero_run_r;
    ones_nxt_s      = ones_r;
    bit_cnt_nxt_s   = bit_cnt_r;
    shift_nxt_s     = shift_r;
    first_nxt_s     = first_r;
    pend_err_nxt_s  = pend_err_r;
    se0_cnt_nxt_s   = se0_cnt_r;
    abort_se0_nxt_s = abort_se0_r;
    active_nxt_s    = rx_active;
    data_nxt_s      = rx_data;
    valid_nxt_s     = 1'b0;
    first_out_nxt_s = 1'b0;
    eop_nxt_s       = 1'b0;
    err_nxt_s       = 1'b0;

    // NRZI: no transition between samples decodes as 1
    bit_s  = (line_cur_s == nrzi_prev_r);
    byte_s = {bit_s, shift_r[7:1]};

    case (state_r)
      ST_IDLE: begin
        // Idle bus is J, so the first K of SYNC decodes as a 0
        nrzi_prev_nxt_s = LINE_J;
        active_nxt_s    = 1'b0;
        if (sample_en_s && (line_cur_s == LINE_K)) begin
          state_nxt_s     = ST_SYNC;
          nrzi_prev_nxt_s = LINE_K;
          zero_run_nxt_s  = 5'd1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_SYNC: begin
        if (!sample_en_s) begin
          state_nxt_s = ST_SYNC;
        end else if (line_cur_s == LINE_SE0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          nrzi_prev_nxt_s = line_cur_s;
          if (bit_s) begin
            if (zero_run_r >= 5'd5) begin
              // The terminating 1 of SYNC counts toward the stuffing run
              state_nxt_s   = ST_DATA;
              active_nxt_s  = 1'b1;
              ones_nxt_s    = 3'd1;
              bit_cnt_nxt_s = 3'd0;
              first_nxt_s   = 1'b1;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else if (zero_run_r == 5'd15) begin
            state_nxt_s = ST_IDLE;
          end else begin
            zero_run_nxt_s = zero_run_r + 5'd1;
          end
        end
      end

      ST_DATA: begin
        if (!sample_en_s) begin
          state_nxt_s = ST_DATA;
        end else if (line_cur_s == LINE_SE0) begin
          state_nxt_s    = ST_EOP;
          pend_err_nxt_s = (bit_cnt_r != 3'd0);
          se0_cnt_nxt_s  = 2'd1;
        end else begin
          nrzi_prev_nxt_s = line_cur_s;
          if (ones_r == 3'd6) begin
            if (bit_s) begin
              err_nxt_s       = 1'b1;
              state_nxt_s     = ST_ABORT;
              abort_se0_nxt_s = 1'b0;
            end else begin
              // Stuffed zero: dropped, run restarts
              ones_nxt_s = 3'd0;
            end
          end else begin
            ones_nxt_s    = bit_s ? (ones_r + 3'd1) : 3'd0;
            shift_nxt_s   = byte_s;
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              first_nxt_s = 1'b0;
              if (first_r && (byte_s[3:0] != ~byte_s[7:4])) begin
                err_nxt_s       = 1'b1;
                state_nxt_s     = ST_ABORT;
                abort_se0_nxt_s = 1'b0;
              end else begin
                valid_nxt_s     = 1'b1;
                first_out_nxt_s = first_r;
                data_nxt_s      = byte_s;
              end
            end else begin
              first_nxt_s = first_r;
            end
          end
        end
      end

      ST_EOP: begin
        if (!sample_en_s) begin
          state_nxt_s = ST_EOP;
        end else if (line_cur_s == LINE_SE0) begin
          // A fourth SE0 sample means a bus reset rather than an EOP
          if (se0_cnt_r == 2'd3) begin
            err_nxt_s    = 1'b1;
            active_nxt_s = 1'b0;
            state_nxt_s  = ST_IDLE;
          end else begin
            se0_cnt_nxt_s = se0_cnt_r + 2'd1;
          end
        end else if (line_cur_s == LINE_J) begin
          err_nxt_s    = pend_err_r;
          eop_nxt_s    = !pend_err_r;
          active_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end else begin
          state_nxt_s = ST_EOP;
        end
      end

      ST_ABORT: begin
        if (!sample_en_s) begin
          state_nxt_s = ST_ABORT;
        end else if (line_cur_s == LINE_SE0) begin
          abort_se0_nxt_s = 1'b1;
        end else if ((line_cur_s == LINE_J) && abort_se0_r) begin
          active_nxt_s = 1'b0;
          state_nxt_s  = ST_IDLE;
        end else begin
          // Data resumed after a short SE0: keep waiting for a real EOP
          abort_se0_nxt_s = 1'b0;
        end
      end

      default: begin
        state_nxt_s  = ST_IDLE;
        active_nxt_s = 1'b0;
      end
    endcase
  end

  // Decoder state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      nrzi_prev_r <= LINE_J;
      zero_run_r  <= 5'd0;
      ones_r      <= 3'd0;
      bit_cnt_r   <= 3'd0;
      shift_r     <= 8'd0;
      first_r     <= 1'b0;
      pend_err_r  <= 1'b0;
      se0_cnt_r   <= 2'd0;
      abort_se0_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      nrzi_prev_r <= nrzi_prev_nxt_s;
      zero_run_r  <= zero_run_nxt_s;
      ones_r      <= ones_nxt_s;
      bit_cnt_r   <= bit_cnt_nxt_s;
      shift_r     <= shift_nxt_s;
      first_r     <= first_nxt_s;
      pend_err_r  <= pend_err_nxt_s;
      se0_cnt_r   <= se0_cnt_nxt_s;
      abort_se0_r <= abort_se0_nxt_s;
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_active <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      rx_first  <= 1'b0;
      rx_eop    <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      rx_active <= active_nxt_s;
      rx_data   <= data_nxt_s;
      rx_valid  <= valid_nxt_s;
      rx_first  <= first_out_nxt_s;
      rx_eop    <= eop_nxt_s;
      rx_err    <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Testbench for usb_rx_decoder: builds line-level packets (NRZI + stuffing),
// plays them onto dp/dm, and checks strobes against a scoreboard queue.
module tb_usb_rx_decoder;

  localparam int CPB_FS = 4;
  localparam int CPB_LS = 32;

  localparam logic [1:0] S_SE0 = 2'd0;
  localparam logic [1:0] S_J   = 2'd1;
  localparam logic [1:0] S_K   = 2'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       is_fs;
  logic       line_dp;
  logic       line_dm;
  logic       rx_active;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       rx_eop;
  logic       rx_err;

  int checks = 0;
  int errors = 0;

  // Expected strobe: {active, kind(1=valid,2=eop,3=err), first, data}
  logic [11:0] exp_q[$];

  logic [1:0] cells[$];
  int         jit[$];
  logic [1:0] cur_level;
  int         ones;
  bit         jitter_en;

  usb_rx_decoder #(.CPB_FS(CPB_FS), .CPB_LS(CPB_LS)) dut (
    .clk       (clk),
    .rst       (rst),
    .is_fs     (is_fs),
    .line_dp   (line_dp),
    .line_dm   (line_dm),
    .rx_active (rx_active),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_first  (rx_first),
    .rx_eop    (rx_eop),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    logic [11:0] e;
    logic [1:0]  kind;
    if (!rst && (rx_valid || rx_eop || rx_err)) begin
      kind = rx_valid ? 2'd1 : (rx_eop ? 2'd2 : 2'd3);
      checks++;
      if ((int'(rx_valid) + int'(rx_eop) + int'(rx_err)) != 1) begin
        errors++;
        $display("FAIL strobe_exclusive: valid=%0b eop=%0b err=%0b, expected exactly one", rx_valid, rx_eop, rx_err);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: kind=%0d data=%02h at %0t, expected none", kind, rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (kind !== e[10:9]) begin
          errors++;
          $display("FAIL strobe_kind: got %0d expected %0d at %0t", kind, e[10:9], $time);
        end
        checks++;
        if (rx_active !== e[11]) begin
          errors++;
          $display("FAIL strobe_active: got %0b expected %0b at %0t", rx_active, e[11], $time);
        end
        if (e[10:9] == 2'd1) begin
          checks++;
          if (rx_data !== e[7:0]) begin
            errors++;
            $display("FAIL byte_data: got %02h expected %02h", rx_data, e[7:0]);
          end
          checks++;
          if (rx_first !== e[8]) begin
            errors++;
            $display("FAIL byte_first: got %0b expected %0b (data %02h)", rx_first, e[8], e[7:0]);
          end
        end
      end
    end
  end

  task automatic exp_valid(input logic [7:0] d, input logic f);
    exp_q.push_back({1'b1, 2'd1, f, d});
  endtask

  task automatic exp_eop();
    exp_q.push_back({1'b0, 2'd2, 1'b0, 8'h00});
  endtask

  task automatic exp_err(input logic act);
    exp_q.push_back({act, 2'd3, 1'b0, 8'h00});
  endtask

  task automatic drive_sym(input logic [1:0] s);
    case (s)
      S_SE0: begin line_dp = 1'b0; line_dm = 1'b0; end
      S_K:   begin line_dp = is_fs ? 1'b0 : 1'b1; line_dm = ~line_dp; end
      default: begin line_dp = is_fs ? 1'b1 : 1'b0; line_dm = ~line_dp; end
    endcase
  endtask

  task automatic new_packet();
    cells.delete();
    jit.delete();
    cur_level = S_J;
    ones = 0;
  endtask

  // Edge jitter: each transition moves by -1..+1 clk around the bit grid
  task automatic push_cell(input logic [1:0] lvl);
    int e;
    e = 0;
    if (jitter_en && (cells.size() > 0)) begin
      if (lvl != cells[cells.size()-1]) e = int'($urandom_range(2, 0)) - 1;
    end
    cells.push_back(lvl);
    jit.push_back(e);
  endtask

  task automatic push_bit(input bit b);
    if (!b) cur_level = (cur_level == S_J) ? S_K : S_J;
    push_cell(cur_level);
    if (b) begin
      ones++;
      if (ones == 6) begin
        cur_level = (cur_level == S_J) ? S_K : S_J;
        push_cell(cur_level);
        ones = 0;
      end
    end else begin
      ones = 0;
    end
  endtask

  task automatic push_sync();
    for (int i = 0; i < 7; i++) push_bit(1'b0);
    push_bit(1'b1);
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) push_bit(b[i]);
  endtask

  task automatic push_eop();
    push_cell(S_SE0);
    push_cell(S_SE0);
    cur_level = S_J;
    push_cell(S_J);
    ones = 0;
  endtask

  task automatic play(input int from, input int upto);
    int cpb, dur, nxt;
    cpb = is_fs ? CPB_FS : CPB_LS;
    for (int i = from; i < upto; i++) begin
      nxt = (i + 1 < cells.size()) ? jit[i+1] : 0;
      dur = cpb - jit[i] + nxt;
      drive_sym(cells[i]);
      repeat (dur) @(negedge clk);
    end
  endtask

  task automatic settle();
    repeat ((is_fs ? CPB_FS : CPB_LS) * 12) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_active, rx_data, rx_valid, rx_first, rx_eop, rx_err} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %04h expected 0000", {rx_active, rx_data, rx_valid, rx_first, rx_eop, rx_err});
    end
    rst = 1'b0;
    repeat (60) @(negedge clk);
    checks++;
    if ({rx_active, rx_data} !== 9'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %03h expected 000", {rx_active, rx_data});
    end
  endtask

  task automatic test_ack();
    new_packet();
    push_sync(); push_byte(8'hD2); push_eop();
    exp_valid(8'hD2, 1'b1); exp_eop();
    play(0, 16 + 2);
    checks++;
    if (rx_active !== 1'b1) begin
      errors++;
      $display("FAIL ack_active_mid: got %0b expected 1", rx_active);
    end
    play(18, cells.size());
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ack_drain: %0d strobes missing, expected 0", exp_q.size());
    end
    checks++;
    if ({rx_active, rx_data} !== {1'b0, 8'hD2}) begin
      errors++;
      $display("FAIL ack_hold: active=%0b data=%02h expected 0/d2", rx_active, rx_data);
    end
  endtask

  task automatic test_data0_stuff();
    logic [7:0] pkt [5];
    pkt = '{8'hC3, 8'hFF, 8'hFF, 8'hFE, 8'hFF};
    new_packet();
    push_sync();
    for (int i = 0; i < 5; i++) begin
      push_byte(pkt[i]);
      exp_valid(pkt[i], (i == 0));
    end
    push_eop();
    exp_eop();
    play(0, cells.size());
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL data0_drain: %0d strobes missing, expected 0", exp_q.size());
    end
    checks++;
    if (cells.size() != 8 + 40 + 5 + 3) begin
      errors++;
      $display("FAIL data0_stuff_count: %0d cells, expected 56", cells.size());
    end
  endtask

  task automatic test_stuff_error();
    int n;
    new_packet();
    push_sync(); push_byte(8'hC3);
    for (int i = 0; i < 7; i++) push_cell(cur_level);
    push_eop();
    exp_valid(8'hC3, 1'b1); exp_err(1'b1);
    n = cells.size();
    play(0, n - 3);
    checks++;
    if ({exp_q.size() == 0, rx_active} !== 2'b11) begin
      errors++;
      $display("FAIL stuff_err_pre_eop: pending=%0d active=%0b expected 0/1", exp_q.size(), rx_active);
    end
    play(n - 3, n);
    settle();
    checks++;
    if (rx_active !== 1'b0) begin
      errors++;
      $display("FAIL stuff_err_active: got %0b expected 0", rx_active);
    end
  endtask

  task automatic test_pid_fail();
    new_packet();
    push_sync(); push_byte(8'hD3); push_byte(8'h00); push_eop();
    exp_err(1'b1);
    play(0, cells.size());
    settle();
    checks++;
    if ({exp_q.size() == 0, rx_active} !== 2'b10) begin
      errors++;
      $display("FAIL pid_fail_end: pending=%0d active=%0b expected 0/0", exp_q.size(), rx_active);
    end
  endtask

  task automatic test_back_to_back();
    new_packet();
    push_sync(); push_byte(8'hD2); push_eop();
    push_cell(S_J);
    push_sync(); push_byte(8'h5A); push_eop();
    exp_valid(8'hD2, 1'b1); exp_eop();
    exp_valid(8'h5A, 1'b1); exp_eop();
    play(0, cells.size());
    settle();
    checks++;
    if ({exp_q.size() == 0, rx_data} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL b2b_end: pending=%0d data=%02h expected 0/5a", exp_q.size(), rx_data);
    end
  endtask

  task automatic test_partial_and_reset();
    new_packet();
    push_sync(); push_byte(8'h69);
    push_bit(1'b1); push_bit(1'b0); push_bit(1'b1);
    push_eop();
    exp_valid(8'h69, 1'b1); exp_err(1'b0);
    play(0, cells.size());
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL partial_drain: %0d strobes missing, expected 0", exp_q.size());
    end
    // Second packet interrupted by reset mid-byte
    new_packet();
    push_sync(); push_byte(8'hC3);
    push_bit(1'b0); push_bit(1'b1); push_bit(1'b0);
    exp_valid(8'hC3, 1'b1);
    play(0, cells.size());
    checks++;
    if ({exp_q.size() == 0, rx_active} !== 2'b11) begin
      errors++;
      $display("FAIL pre_reset: pending=%0d active=%0b expected 0/1", exp_q.size(), rx_active);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rx_active, rx_data, rx_valid, rx_first, rx_eop, rx_err} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: got %04h expected 0000", {rx_active, rx_data, rx_valid, rx_first, rx_eop, rx_err});
    end
    drive_sym(S_J);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    settle();
    new_packet();
    push_sync(); push_byte(8'hD2); push_eop();
    exp_valid(8'hD2, 1'b1); exp_eop();
    play(0, cells.size());
    settle();
    checks++;
    if ({exp_q.size() == 0, rx_active, rx_data} !== {1'b1, 1'b0, 8'hD2}) begin
      errors++;
      $display("FAIL ack_after_reset: pending=%0d active=%0b data=%02h expected 0/0/d2", exp_q.size(), rx_active, rx_data);
    end
  endtask

  task automatic test_ls_mode();
    is_fs = 1'b0;
    drive_sym(S_J);
    repeat (200) @(negedge clk);
    jitter_en = 1'b1;
    new_packet();
    push_sync(); push_byte(8'hA5); push_byte(8'h12); push_byte(8'h34); push_eop();
    exp_valid(8'hA5, 1'b1); exp_valid(8'h12, 1'b0); exp_valid(8'h34, 1'b0); exp_eop();
    play(0, cells.size());
    settle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL ls_drain: %0d strobes missing, expected 0", exp_q.size());
    end
    checks++;
    if ({rx_active, rx_data} !== {1'b0, 8'h34}) begin
      errors++;
      $display("FAIL ls_end: active=%0b data=%02h expected 0/34", rx_active, rx_data);
    end
    jitter_en = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    is_fs     = 1'b1;
    jitter_en = 1'b0;
    cur_level = S_J;
    ones      = 0;
    drive_sym(S_J);
    test_reset();
    test_ack();
    test_data0_stuff();
    test_stuff_error();
    test_pid_fail();
    test_back_to_back();
    test_partial_and_reset();
    test_ls_mode();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: %0d strobes missing, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
